nibble_serial_adder: RTL and testbench

//  Sequential front-end that adds two WIDTH-bit operands 4 bits per clock through one

---
 rtl/adder_pkg.sv | 22 ++
 rtl/four_bit_adder.sv | 14 +
 rtl/nibble_serial_adder.sv | 137 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and types for the nibble-serial adder.
// NIBBLE is the slice width handled per clock; state_t encodes the
// sequencing FSM; clog2 sizes the nibble counter.
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Purely combinational 4-bit ripple adder: {c_out, sum} = x + y + c_in.
module four_bit_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] x,
  input  logic [NIBBLE-1:0] y,
  input  logic              c_in,
  output logic [NIBBLE-1:0] sum,
  output logic              c_out
);

  assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {{NIBBLE{1'b0}}, c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two WIDTH-bit operands one nibble per clock
// through a single four_bit_adder, chaining the carry through a register.
// Valid/ready handshake on both sides; result held in DONE until taken.
// Optional macro NIBBLE_ADDER_OVF_EN adds a signed-overflow output ovf.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef NIBBLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE;
  localparam int CNT_W = clog2(NIB);

  state_t state_reg, state_next;

  logic [WIDTH-1:0]  a_reg, b_reg, sum_reg;
  logic              carry_reg, c_out_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              last_nib;

  logic [NIBBLE-1:0] nib_sum;
  logic              nib_carry;

  // Low nibbles of the shifting operands plus the chained carry.
  four_bit_adder u_adder (
    .x     (a_reg[NIBBLE-1:0]),
    .y     (b_reg[NIBBLE-1:0]),
    .c_in  (carry_reg),
    .sum   (nib_sum),
    .c_out (nib_carry)
  );

  assign last_nib = (cnt_reg == CNT_W'(NIB - 1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs; ready/valid come straight from state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one nibble per RUN cycle.
  // Sum nibbles enter at the top so after NIB shifts sum_reg is aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= c_in;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> NIBBLE;
          b_reg     <= b_reg >> NIBBLE;
          sum_reg   <= {nib_sum, sum_reg[WIDTH-1:NIBBLE]};
          carry_reg <= nib_carry;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_nib) c_out_reg <= nib_carry;
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;

`ifdef NIBBLE_ADDER_OVF_EN
  logic sign_a_reg, sign_b_reg, ovf_reg;

  // Operand sign bits are captured at accept (the shift registers lose them);
  // overflow is resolved on the final nibble from the result's sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        sign_a_reg <= a[WIDTH-1];
        sign_b_reg <= b[WIDTH-1];
      end
      if (state_reg == RUN && last_nib)
        ovf_reg <= (sign_a_reg == sign_b_reg) && (nib_sum[NIBBLE-1] != sign_a_reg);
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases on a 16-bit
// instance, randomized traffic on 16-bit and 8-bit instances, compared against
// plain-arithmetic expectations. Honours NIBBLE_ADDER_OVF_EN when defined.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, c_in, c_out;
  logic [15:0] a, b, sum;
  // 8-bit instance
  logic        iv8, ir8, ov8, or8, cin8, co8;
  logic [7:0]  a8, b8, sum8;
`ifdef NIBBLE_ADDER_OVF_EN
  logic        ovf, ovf8;
`endif

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out)
`ifdef NIBBLE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .c_in(cin8), .out_valid(ov8), .out_ready(or8),
    .sum(sum8), .c_out(co8)
`ifdef NIBBLE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the 16-bit instance with `hold` cycles of back-pressure.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int hold);
    logic [16:0] r;
    int n;
    r = {1'b0, ta} + {1'b0, tb} + {16'd0, tc};
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_before_op", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; c_in = tc; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency16", n, 32'd4);
    chk("sum16", {16'd0, sum}, {16'd0, r[15:0]});
    chk("c_out16", {31'd0, c_out}, {31'd0, r[16]});
`ifdef NIBBLE_ADDER_OVF_EN
    chk("ovf16", {31'd0, ovf}, {31'd0, (ta[15] == tb[15]) && (r[15] != ta[15])});
`endif
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {16'd0, sum}, {16'd0, r[15:0]});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  logic [16:0] expq [2];
  logic [8:0]  r8;
  int accepts, got, n, hold;
  int acc_cyc [2];
  logic will_accept;

  initial begin
    in_valid = 0; out_ready = 0; a = 0; b = 0; c_in = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    chk("rst_in_ready8", {31'd0, ir8}, 32'd1);
    chk("rst_out_valid8", {31'd0, ov8}, 32'd0);
`ifdef NIBBLE_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripples through every nibble; no back-pressure
    op16(16'hFFFF, 16'h0001, 1'b0, 0);
    // Back-pressure for three cycles
    op16(16'h1234, 16'h4321, 1'b1, 3);
    // Signed-overflow cases (ovf checked only when the port exists)
    op16(16'h7FFF, 16'h0001, 1'b0, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 1);

    // Back-to-back with in_valid held high
    expq[0] = 17'h00100; expq[1] = 17'h10000;
    a = 16'h00FF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    accepts = 0; got = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int t = 0; t < 40 && got < 2; t++) begin
      will_accept = in_ready && in_valid;
      @(posedge clk); #1;
      if (will_accept) begin
        if (accepts < 2) acc_cyc[accepts] = t;
        accepts++;
        if (accepts == 1) begin a = 16'h8000; b = 16'h8000; end
        else in_valid = 1'b0;
      end
      if (out_valid && got < 2) begin
        chk("b2b_result", {15'd0, c_out, sum}, {15'd0, expq[got]});
        got++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", got, 32'd2);
    chk("b2b_accepts", accepts, 32'd2);
    chk("b2b_interval", acc_cyc[1] - acc_cyc[0], 32'd6);
    @(posedge clk); #1;

    // Reset two edges after accept aborts the operation
    a = 16'h5555; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_c_out", {31'd0, c_out}, 32'd0);
    #10 rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("abort_no_emit", n, 32'd0);

    // Random traffic, 16-bit
    for (int i = 0; i < 50; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

    // Random traffic, 8-bit
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
      chk("idle8", {31'd0, ir8}, 32'd1);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      hold = int'($urandom_range(0, 2));
      r8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      iv8 = 1'b1; or8 = (hold == 0);
      @(posedge clk); #1;
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency8", n, 32'd2);
      chk("sum8", {24'd0, sum8}, {24'd0, r8[7:0]});
      chk("c_out8", {31'd0, co8}, {31'd0, r8[8]});
`ifdef NIBBLE_ADDER_OVF_EN
      chk("ovf8", {31'd0, ovf8}, {31'd0, (a8[7] == b8[7]) && (r8[7] != a8[7])});
`endif
      repeat (hold) begin @(posedge clk); #1; end
      chk("held8", {23'd0, ov8, sum8}, {23'd0, 1'b1, r8[7:0]});
      or8 = 1'b1;
      @(posedge clk); #1;
      chk("drop8", {31'd0, ov8}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
